// File: rtl/mmac_pkg.sv
// rtl/mmac_pkg.sv - shared constants, state type and element offset helper for the mmac engine
// Purpose: default dimensions for matrix_mac_seq, its FSM state type and the
//          row-major flattened element offset used by every file of the block.
// Ports:   none (package).
package mmac_pkg;

  localparam int DEF_M_SIZE    = 4;
  localparam int DEF_VAR_WIDTH = 8;
  localparam int DEF_ACC_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Bit offset of element (i,j) in a row-major flattened m_size x m_size matrix.
  function automatic int elem_offset(input int i, input int j, input int m_size, input int width);
    return (i * m_size + j) * width;
  endfunction

endpackage

// File: rtl/mmac_row.sv
// rtl/mmac_row.sv - combinational rank-1 update of one accumulator row
// Purpose: C[i][j] = base[i][j] + a * B[k][j] for every column j of one row.
// Ports:
//   i_a         - scalar A[i][k]
//   i_b_row     - row B[k][*], flattened, column 0 in the low bits
//   i_base_row  - current C[i][*], flattened
//   i_zero_base - treat the base row as zero (first step of an overwrite)
//   o_c_row     - updated C[i][*], wrapped modulo 2^ACC_WIDTH
//   o_carry     - set when any column of this row wrapped
module mmac_row
  import mmac_pkg::*;
#(
  parameter int M_SIZE    = DEF_M_SIZE,
  parameter int VAR_WIDTH = DEF_VAR_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic [VAR_WIDTH-1:0]          i_a,
  input  logic [M_SIZE*VAR_WIDTH-1:0]   i_b_row,
  input  logic [M_SIZE*ACC_WIDTH-1:0]   i_base_row,
  input  logic                          i_zero_base,
  output logic [M_SIZE*ACC_WIDTH-1:0]   o_c_row,
  output logic                          o_carry
);

  logic [M_SIZE-1:0] w_carry;

  for (genvar j = 0; j < M_SIZE; j++) begin : g_col
    logic [2*VAR_WIDTH-1:0] w_prod;
    logic [ACC_WIDTH-1:0]   w_base;
    logic [ACC_WIDTH:0]     w_sum;

    assign w_prod = {{VAR_WIDTH{1'b0}}, i_a} *
                    {{VAR_WIDTH{1'b0}}, i_b_row[elem_offset(0, j, M_SIZE, VAR_WIDTH) +: VAR_WIDTH]};
    assign w_base = i_zero_base ? '0 : i_base_row[elem_offset(0, j, M_SIZE, ACC_WIDTH) +: ACC_WIDTH];
    // One extra bit captures the wrap out of the accumulator width.
    assign w_sum  = {1'b0, w_base} + {{(ACC_WIDTH + 1 - 2*VAR_WIDTH){1'b0}}, w_prod};

    assign o_c_row[elem_offset(0, j, M_SIZE, ACC_WIDTH) +: ACC_WIDTH] = w_sum[ACC_WIDTH-1:0];
    assign w_carry[j] = w_sum[ACC_WIDTH];
  end

  assign o_carry = |w_carry;

endmodule

// File: rtl/matrix_mac_seq.sv
// rtl/matrix_mac_seq.sv - handshaked sequential matrix multiply-accumulate engine
// Purpose: C = A*B or C = C + A*B using one rank-1 update per cycle; C is held
//          in an internal bank and presented on a valid/ready output.
// Ports:
//   clock, reset          - clock; asynchronous active-low reset
//   in_valid/in_ready     - operand pair handshake
//   acc_mode              - 1 accumulate into C, 0 overwrite C (sampled on accept)
//   matrixA/matrixB       - row-major flattened operand matrices
//   enable                - advances COMPUTE; low freezes it
//   clear                 - zeroes C and overflow while IDLE
//   out_valid/out_ready   - result handshake
//   result                - row-major flattened C
//   overflow              - sticky accumulator wrap flag
module matrix_mac_seq
  import mmac_pkg::*;
#(
  parameter int M_SIZE    = DEF_M_SIZE,
  parameter int VAR_WIDTH = DEF_VAR_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  acc_mode,
  input  logic [M_SIZE*M_SIZE*VAR_WIDTH-1:0]    matrixA,
  input  logic [M_SIZE*M_SIZE*VAR_WIDTH-1:0]    matrixB,
  input  logic                                  enable,
  input  logic                                  clear,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [M_SIZE*M_SIZE*ACC_WIDTH-1:0]    result,
  output logic                                  overflow
);

  localparam int KW    = $clog2(M_SIZE);
  localparam int ROW_V = M_SIZE * VAR_WIDTH;
  localparam int ROW_A = M_SIZE * ACC_WIDTH;

  state_t                               r_state;
  logic [KW-1:0]                        r_k;
  logic [M_SIZE*M_SIZE*VAR_WIDTH-1:0]   r_a;
  logic [M_SIZE*M_SIZE*VAR_WIDTH-1:0]   r_b;
  logic                                 r_acc_mode;
  logic [M_SIZE*M_SIZE*ACC_WIDTH-1:0]   r_c;
  logic                                 r_overflow;
  logic                                 r_out_valid;

  int                                   w_k;
  logic                                 w_zero_base;
  logic [M_SIZE*M_SIZE*ACC_WIDTH-1:0]   w_c_next;
  logic [M_SIZE-1:0]                    w_row_carry;

  assign w_k = int'(r_k);
  // Overwrite mode discards the previous C only on the first rank-1 step.
  assign w_zero_base = (r_k == '0) && !r_acc_mode;

  for (genvar i = 0; i < M_SIZE; i++) begin : g_row
    mmac_row #(
      .M_SIZE    (M_SIZE),
      .VAR_WIDTH (VAR_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_row (
      .i_a         (r_a[elem_offset(i, w_k, M_SIZE, VAR_WIDTH) +: VAR_WIDTH]),
      .i_b_row     (r_b[elem_offset(w_k, 0, M_SIZE, VAR_WIDTH) +: ROW_V]),
      .i_base_row  (r_c[elem_offset(i, 0, M_SIZE, ACC_WIDTH) +: ROW_A]),
      .i_zero_base (w_zero_base),
      .o_c_row     (w_c_next[elem_offset(i, 0, M_SIZE, ACC_WIDTH) +: ROW_A]),
      .o_carry     (w_row_carry[i])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc_mode  <= 1'b0;
      r_c         <= '0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // clear has priority over an offered operand pair.
          if (clear) begin
            r_c        <= '0;
            r_overflow <= 1'b0;
          end else if (in_valid) begin
            r_a        <= matrixA;
            r_b        <= matrixB;
            r_acc_mode <= acc_mode;
            r_k        <= '0;
            r_state    <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (enable) begin
            r_c <= w_c_next;
            if (|w_row_carry) begin
              r_overflow <= 1'b1;
            end
            if (r_k == KW'(M_SIZE - 1)) begin
              r_k         <= '0;
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_k <= r_k + KW'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) && !clear;
  assign out_valid = r_out_valid;
  assign result    = r_c;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_matrix_mac_seq.sv
// tb/tb_matrix_mac_seq.sv - self-checking bench for matrix_mac_seq (32-bit and 18-bit accumulators)
module tb_matrix_mac_seq;

  localparam int M   = 4;
  localparam int VW  = 8;
  localparam int AW  = 32;
  localparam int AW2 = 18;
  localparam int MW  = M * M * VW;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          in_valid  = 1'b0;
  logic          acc_mode  = 1'b0;
  logic          enable    = 1'b1;
  logic          clear     = 1'b0;
  logic          out_ready = 1'b0;
  logic [MW-1:0] matrixA   = '0;
  logic [MW-1:0] matrixB   = '0;

  logic                in_ready, out_valid, overflow;
  logic [M*M*AW-1:0]   result;
  logic                in_ready_s, out_valid_s, overflow_s;
  logic [M*M*AW2-1:0]  result_s;

  matrix_mac_seq #(.M_SIZE(M), .VAR_WIDTH(VW), .ACC_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .acc_mode(acc_mode), .matrixA(matrixA), .matrixB(matrixB), .enable(enable),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow)
  );

  matrix_mac_seq #(.M_SIZE(M), .VAR_WIDTH(VW), .ACC_WIDTH(AW2)) dut18 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .acc_mode(acc_mode), .matrixA(matrixA), .matrixB(matrixB), .enable(enable),
    .clear(clear), .out_valid(out_valid_s), .out_ready(out_ready), .result(result_s),
    .overflow(overflow_s)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_vec(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: plain matrix arithmetic, one model per accumulator width.
  longint unsigned mc [2][M][M];
  bit              mov [2];

  function automatic int width_of(input int d);
    return (d == 0) ? AW : AW2;
  endfunction

  function automatic logic [VW-1:0] el(input logic [MW-1:0] m, input int i, input int j);
    return m[(i*M + j)*VW +: VW];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mov[d] = 1'b0;
      for (int i = 0; i < M; i++)
        for (int j = 0; j < M; j++) mc[d][i][j] = 0;
    end
  endtask

  task automatic model_txn(input logic [MW-1:0] a, input logic [MW-1:0] b, input bit accm);
    longint unsigned lim, s;
    for (int d = 0; d < 2; d++) begin
      lim = 64'd1 << width_of(d);
      if (!accm)
        for (int i = 0; i < M; i++)
          for (int j = 0; j < M; j++) mc[d][i][j] = 0;
      for (int k = 0; k < M; k++)
        for (int i = 0; i < M; i++)
          for (int j = 0; j < M; j++) begin
            s = mc[d][i][j] + longint'(el(a, i, k)) * longint'(el(b, k, j));
            if (s >= lim) mov[d] = 1'b1;
            mc[d][i][j] = s % lim;
          end
    end
  endtask

  function automatic logic [511:0] exp_vec(input int d);
    logic [511:0] v = '0;
    int aw = width_of(d);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        for (int bt = 0; bt < aw; bt++) v[(i*M + j)*aw + bt] = mc[d][i][j][bt];
    return v;
  endfunction

  function automatic logic [511:0] uni_res(input int aw, input longint unsigned val);
    logic [511:0] v = '0;
    for (int e = 0; e < M*M; e++)
      for (int bt = 0; bt < aw; bt++) v[e*aw + bt] = val[bt];
    return v;
  endfunction

  function automatic logic [MW-1:0] rand_mat();
    logic [MW-1:0] m;
    for (int e = 0; e < M*M; e++) m[e*VW +: VW] = VW'($urandom_range(0, 255));
    return m;
  endfunction

  // Waits from just after the accept edge until out_valid; optional 3-cycle stall at k==1.
  task automatic wait_done(input bit stall, output int lat);
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      lat++;
      if (lat == 1) in_valid = 1'b0;
      if (stall && lat == 2) enable = 1'b0;
      if (stall && lat == 5) enable = 1'b1;
      if (out_valid) break;
    end
    enable = 1'b1;
  endtask

  task automatic run_txn(input logic [MW-1:0] a, input logic [MW-1:0] b, input bit accm,
                         input bit stall, output int lat);
    @(negedge clock);
    check_bit("in_ready_before_accept", in_ready, 1'b1);
    matrixA  = a;
    matrixB  = b;
    acc_mode = accm;
    in_valid = 1'b1;
    @(posedge clock);
    model_txn(a, b, accm);
    wait_done(stall, lat);
  endtask

  task automatic check_out(input string tag);
    check_vec({tag, "_res32"}, 512'(result), exp_vec(0));
    check_vec({tag, "_res18"}, 512'(result_s), exp_vec(1));
    check_bit({tag, "_ovf32"}, overflow, mov[0]);
    check_bit({tag, "_ovf18"}, overflow_s, mov[1]);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check_bit("out_valid_after_transfer", out_valid, 1'b0);
  endtask

  typedef struct {
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    bit            accm;
    bit            exp_is_b;
    int unsigned   exp32;
    int unsigned   exp18;
    bit            ov32;
    bit            ov18;
    int            lat;
  } vec_t;

  vec_t tbl [3];

  initial begin
    int            lat;
    logic [MW-1:0] id_m, seq_m, ones, ra, rb, rc;
    logic [511:0]  e32, e18;

    model_reset();
    repeat (2) @(negedge clock);
    check_bit("reset_in_ready", in_ready, 1'b1);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_vec("reset_result", 512'(result), '0);
    check_bit("reset_overflow", overflow, 1'b0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        id_m[(i*M + j)*VW +: VW]  = (i == j) ? 8'd1 : 8'd0;
        seq_m[(i*M + j)*VW +: VW] = VW'(4*i + j);
        ones[(i*M + j)*VW +: VW]  = 8'd255;
      end

    tbl[0].a = id_m; tbl[0].b = seq_m; tbl[0].accm = 1'b0; tbl[0].exp_is_b = 1'b1;
    tbl[0].exp32 = 0; tbl[0].exp18 = 0; tbl[0].ov32 = 1'b0; tbl[0].ov18 = 1'b0; tbl[0].lat = 5;
    tbl[1].a = ones; tbl[1].b = ones; tbl[1].accm = 1'b0; tbl[1].exp_is_b = 1'b0;
    tbl[1].exp32 = 260100; tbl[1].exp18 = 260100; tbl[1].ov32 = 1'b0; tbl[1].ov18 = 1'b0; tbl[1].lat = 5;
    tbl[2].a = ones; tbl[2].b = ones; tbl[2].accm = 1'b1; tbl[2].exp_is_b = 1'b0;
    tbl[2].exp32 = 520200; tbl[2].exp18 = 258056; tbl[2].ov32 = 1'b0; tbl[2].ov18 = 1'b1; tbl[2].lat = 5;

    for (int t = 0; t < 3; t++) begin
      run_txn(tbl[t].a, tbl[t].b, tbl[t].accm, 1'b0, lat);
      check_int($sformatf("tbl%0d_latency", t), lat, tbl[t].lat);
      if (tbl[t].exp_is_b) begin
        e32 = '0;
        e18 = '0;
        for (int e = 0; e < M*M; e++) begin
          e32[e*AW +: AW]   = AW'(tbl[t].b[e*VW +: VW]);
          e18[e*AW2 +: AW2] = AW2'(tbl[t].b[e*VW +: VW]);
        end
      end else begin
        e32 = uni_res(AW, tbl[t].exp32);
        e18 = uni_res(AW2, tbl[t].exp18);
      end
      check_vec($sformatf("tbl%0d_res32", t), 512'(result), e32);
      check_vec($sformatf("tbl%0d_res18", t), 512'(result_s), e18);
      check_bit($sformatf("tbl%0d_ovf32", t), overflow, tbl[t].ov32);
      check_bit($sformatf("tbl%0d_ovf18", t), overflow_s, tbl[t].ov18);
      release_out();
    end

    // clear wins over a simultaneous in_valid
    @(negedge clock);
    clear    = 1'b1;
    in_valid = 1'b1;
    matrixA  = ones;
    #1;
    check_bit("in_ready_under_clear", in_ready, 1'b0);
    @(negedge clock);
    clear    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #1;
    check_vec("clear_res32", 512'(result), '0);
    check_vec("clear_res18", 512'(result_s), '0);
    check_bit("clear_ovf18", overflow_s, 1'b0);
    check_bit("clear_no_accept", in_ready, 1'b1);

    for (int n = 0; n < 8; n++) begin
      run_txn(rand_mat(), rand_mat(), 1'($urandom_range(0, 1)), 1'b0, lat);
      check_int($sformatf("rand%0d_latency", n), lat, 5);
      check_out($sformatf("rand%0d", n));
      release_out();
    end

    // Back-pressure in DONE with the next operand pair already offered
    run_txn(rand_mat(), rand_mat(), 1'b0, 1'b0, lat);
    check_int("hold_latency", lat, 5);
    ra = rand_mat();
    rb = rand_mat();
    matrixA  = ra;
    matrixB  = rb;
    acc_mode = 1'b1;
    in_valid = 1'b1;
    for (int h = 0; h < 10; h++) begin
      @(negedge clock);
      check_bit("hold_out_valid", out_valid, 1'b1);
      check_bit("hold_in_ready", in_ready, 1'b0);
      check_vec("hold_res32", 512'(result), exp_vec(0));
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check_bit("in_ready_after_transfer", in_ready, 1'b1);
    @(posedge clock);
    model_txn(ra, rb, 1'b1);
    wait_done(1'b0, lat);
    check_int("back_to_back_latency", lat, 5);
    check_out("back_to_back");
    release_out();

    // Stalled run must give the same result, three cycles later
    ra = rand_mat();
    rb = rand_mat();
    run_txn(ra, rb, 1'b0, 1'b0, lat);
    check_int("unstalled_latency", lat, 5);
    check_out("unstalled");
    release_out();
    run_txn(ra, rb, 1'b0, 1'b1, lat);
    check_int("stalled_latency", lat, 8);
    check_out("stalled");
    release_out();

    // Reset in the middle of COMPUTE at k==2
    @(negedge clock);
    matrixA  = rand_mat();
    matrixB  = rand_mat();
    acc_mode = 1'b1;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    #1;
    check_bit("midreset_in_ready", in_ready, 1'b1);
    check_bit("midreset_out_valid", out_valid, 1'b0);
    check_vec("midreset_res32", 512'(result), '0);
    check_vec("midreset_res18", 512'(result_s), '0);
    check_bit("midreset_ovf", overflow, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    rc = rand_mat();
    run_txn(rc, rand_mat(), 1'b1, 1'b0, lat);
    check_int("post_reset_latency", lat, 5);
    check_out("post_reset");
    release_out();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/matrix_mac_seq.md
# matrix_mac_seq

Parametrised, handshaked matrix multiply-accumulate engine.
- Accepts one pair of M_SIZE×M_SIZE unsigned operand matrices per transaction and computes C = A·B (overwrite) or C = C + A·B (accumulate).
- Uses one rank-1 update per cycle, so a product takes M_SIZE compute cycles.
- Holds C in an internal accumulator bank and presents it on a valid/ready output.
- Sits between the operand fetch logic and the result write-back path of the mmac datapath.

## Interface
Parameters:
- M_SIZE, 4, matrix dimension; must be ≥2.
- VAR_WIDTH, 8, unsigned operand element width.
- ACC_WIDTH, 32, accumulator/result element width; must be ≥2*VAR_WIDTH.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clock, input, 1, the single clock.
  - reset, input, 1, asynchronous, active-low.
- Operand input:
  - in_valid, input, 1, operand pair valid.
  - in_ready, output, 1, engine can accept an operand pair.
  - acc_mode, input, 1, sampled with operands; 1 = accumulate into C, 0 = overwrite C.
  - matrixA, input, M_SIZE*M_SIZE*VAR_WIDTH, flattened row-major; element (i,j) is at bit offset (i*M_SIZE+j)*VAR_WIDTH.
  - matrixB, input, M_SIZE*M_SIZE*VAR_WIDTH, same packing as matrixA.
- Control:
  - enable, input, 1, compute advance; low freezes COMPUTE.
  - clear, input, 1, zeroes C and overflow; honoured in IDLE only.
- Result output:
  - out_valid, output, 1, result valid.
  - out_ready, input, 1, consumer accepts the result.
  - result, output, M_SIZE*M_SIZE*ACC_WIDTH, C flattened row-major; element (i,j) is at offset (i*M_SIZE+j)*ACC_WIDTH.
  - overflow, output, 1, sticky; set if any accumulator element wrapped since the last clear or reset.

## Operation
- State machine:
  - IDLE: in_ready = !clear.
    - clear=1 → C and overflow become zero at the next edge.
    - in_valid & in_ready → register A, B and acc_mode; k=0; go to COMPUTE.
  - COMPUTE, when enable=1:
    - for all i,j: C[i][j] ← base[i][j] + A[i][k]*B[k][j].
    - base = 0 when k==0 and acc_mode==0; otherwise base = C.
    - k increments; after the update with k==M_SIZE-1, go to DONE.
  - COMPUTE, when enable=0: C and k hold.
  - DONE: out_valid=1 and result=C, held stable. out_ready=1 → IDLE.
- Arithmetic:
  - Products are 2*VAR_WIDTH bits, zero-extended to ACC_WIDTH.
  - Sums wrap modulo 2^ACC_WIDTH.
  - A carry out of any element sets overflow. overflow clears only on reset or clear.
- C persists across transactions, so accumulate mode chains products.
- clear and enable are ignored outside their stated states.
- Reset (asynchronous, any state, including mid-COMPUTE):
  - state=IDLE, k=0, C=0, overflow=0, registered operands=0.
  - The in-flight transaction is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, overflow=0.
- Latency, with enable held high:
  - Accept edge at cycle T; COMPUTE occupies cycles T+1..T+M_SIZE.
  - out_valid rises in cycle T+M_SIZE+1.
  - Each enable-low cycle during COMPUTE adds one cycle.
- Handshakes:
  - Input: a transfer occurs on an edge where in_valid & in_ready.
  - Output: a transfer occurs on an edge where out_valid & out_ready.
- in_ready=0 in COMPUTE and DONE. The next accept can occur in the cycle after result acceptance.
- Throughput: one transaction per M_SIZE+2 cycles.
- result changes only at COMPUTE edges. It is stable throughout DONE.
- overflow updates on the same edge as the wrapping update.
- Simultaneous clear & in_valid in IDLE: clear wins, no accept.

## Structure
- mmac_pkg holds:
  - default constants M_SIZE, VAR_WIDTH, ACC_WIDTH;
  - state typedef enum {IDLE, COMPUTE, DONE};
  - a function giving the flattened bit offset of element (i,j).
- Sub-module mmac_row, instantiated M_SIZE times:
  - inputs: one scalar A[i][k], the B[k][*] row, the base row and a zero-base flag;
  - outputs: the updated C[i][*] row and a per-row carry-out;
  - it is combinational; the top level owns all registers and the FSM.

## Test plan
All scenarios use M_SIZE=4, VAR_WIDTH=8 unless noted.
- Identity × B, acc_mode=0, B(i,j)=4i+j → result equals B; out_valid first seen 5 cycles after the accept edge; overflow=0.
- All operands 255, acc_mode=0 → every element 260100.
  - Repeat with acc_mode=1 → every element 520200.
- ACC_WIDTH=18 instance, scenario above → first result 260100, overflow=0.
  - Accumulate pass → every element 258056 (wrapped), overflow=1.
  - clear in IDLE → result=0, overflow=0.
- out_ready held low 10 cycles in DONE → result stable, out_valid held, in_ready=0.
  - Upstream in_valid held high → accepted exactly 1 cycle after the result transfer.
- enable low for 3 cycles at k=1 → out_valid delayed 3 cycles; result identical to the unstalled run.
- reset asserted at k=2, then in_valid held low → in_ready=1, out_valid=0, result=0 immediately.
  - After reset release, a fresh transaction completes correctly.
